// File: rtl/pc_seq_pkg.sv
// Shared types for the fetch-stage program-counter sequencer.
// The state and next-source enums are visible to the bench through dbg_state.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    // Which rule chose the next PC; listed from highest to lowest priority.
    typedef enum logic [2:0] {
        SRC_START = 3'd0,
        SRC_HOLD  = 3'd1,
        SRC_RET   = 3'd2,
        SRC_CALL  = 3'd3,
        SRC_BR    = 3'd4,
        SRC_INC   = 3'd5
    } pc_src_t;

    function automatic logic src_moves_pc(input pc_src_t src);
        return src != SRC_HOLD;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: DEPTH entries of W bits, push/pop with full/empty status.
// clr empties the stack in one cycle; pop wins when push and pop coincide.
module pc_ras #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top_data,
    output logic         full,
    output logic         empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);

    // The occupancy counter doubles as the write pointer; entry cnt_q-1 is the top.
    always_comb begin
        top_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i + 1) == cnt_q) begin
                top_data = mem_q[i];
            end
        end
    end

    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (pop && !empty) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (push && !full) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == cnt_q) begin
                    mem_d[i] = push_data;
                end
            end
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            mem_q <= '{default: '0};
        end else begin
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage: sequential, relative, LUT-absolute,
// call/return via pc_ras, stall hold and an IDLE/RUN/HALT FSM with halt on HALT_ADDR.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W      = 10,
    parameter int OFF_W     = 8,
    parameter int LUT_DEPTH = 4,
    parameter int RAS_DEPTH = 4,
    parameter int HALT_ADDR = 1023
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    input  logic                         start,
    input  logic [PC_W-1:0]              start_address,
    input  logic                         stall,
    input  logic                         branch,
    input  logic                         taken,
    input  logic [OFF_W-1:0]             target,
    input  logic                         lut_sel,
    input  logic [$clog2(LUT_DEPTH)-1:0] lut_idx,
    input  logic                         call,
    input  logic                         ret,
    input  logic                         lut_wr_en,
    input  logic [$clog2(LUT_DEPTH)-1:0] lut_wr_idx,
    input  logic [PC_W-1:0]              lut_wr_data,
    output logic [PC_W-1:0]              PC,
    output logic                         halt,
    output logic                         ras_overflow,
    output logic                         ras_underflow,
    output pc_state_t                    dbg_state
);

    localparam logic [PC_W-1:0] HALT_PC = PC_W'(HALT_ADDR);

    pc_state_t       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            halt_q, halt_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic [PC_W-1:0] lut_q [LUT_DEPTH];
    logic [PC_W-1:0] lut_d [LUT_DEPTH];

    pc_src_t         src;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] off_sext;
    logic [PC_W-1:0] jump_dst;
    logic [PC_W-1:0] ras_top;
    logic            ras_push, ras_pop, ras_clr;
    logic            ras_full, ras_empty;

    // Modulo-2**PC_W arithmetic falls out of the fixed result width.
    assign pc_inc   = pc_q + PC_W'(1);
    assign off_sext = PC_W'($signed(target));
    assign jump_dst = lut_sel ? lut_q[lut_idx] : (pc_q + off_sext);

    always_comb begin
        src = SRC_HOLD;
        if (start) begin
            src = SRC_START;
        end else if (state_q == RUN) begin
            if (stall) begin
                src = SRC_HOLD;
            end else if (ret) begin
                src = SRC_RET;
            end else if (call) begin
                src = SRC_CALL;
            end else if (branch && taken) begin
                src = SRC_BR;
            end else begin
                src = SRC_INC;
            end
        end
    end

    always_comb begin
        case (src)
            SRC_START: pc_d = start_address;
            SRC_RET:   pc_d = ras_empty ? pc_inc : ras_top;
            SRC_CALL:  pc_d = jump_dst;
            SRC_BR:    pc_d = jump_dst;
            SRC_INC:   pc_d = pc_inc;
            default:   pc_d = pc_q;
        endcase
    end

    // Whenever the PC is actually re-selected, landing on HALT_ADDR ends the program.
    always_comb begin
        state_d = state_q;
        if (src_moves_pc(src)) begin
            state_d = (pc_d == HALT_PC) ? HALT : RUN;
        end
        halt_d = (state_d == HALT);
    end

    always_comb begin
        ras_clr  = (src == SRC_START);
        ras_push = (src == SRC_CALL) && !ras_full;
        ras_pop  = (src == SRC_RET) && !ras_empty;
        ovf_d    = ras_clr ? 1'b0 : (ovf_q || ((src == SRC_CALL) && ras_full));
        unf_d    = ras_clr ? 1'b0 : (unf_q || ((src == SRC_RET) && ras_empty));
    end

    // LUT writes go in at the edge, so a same-cycle read above still sees the old entry.
    always_comb begin
        lut_d = lut_q;
        if (lut_wr_en) begin
            lut_d[lut_wr_idx] = lut_wr_data;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            pc_q    <= '0;
            halt_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            lut_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            halt_q  <= halt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            lut_q   <= lut_d;
        end
    end

    pc_ras #(
        .DEPTH(RAS_DEPTH),
        .W    (PC_W)
    ) u_ras (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .clr      (ras_clr),
        .push     (ras_push),
        .pop      (ras_pop),
        .push_data(pc_inc),
        .top_data (ras_top),
        .full     (ras_full),
        .empty    (ras_empty)
    );

    assign PC            = pc_q;
    assign halt          = halt_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a queue/array reference model feeds an expected queue
// checked every cycle, alongside hand-computed literal expectations.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam int PC_W      = 10;
    localparam int OFF_W     = 8;
    localparam int LUT_DEPTH = 4;
    localparam int RAS_DEPTH = 4;
    localparam int HALT_ADDR = 1023;
    localparam int MOD       = 1 << PC_W;
    localparam int EXP_W     = PC_W + 4;

    logic              CLK = 1'b0;
    logic              RESET_N;
    logic              start, stall, branch, taken, lut_sel, call, ret, lut_wr_en;
    logic [PC_W-1:0]   start_address, lut_wr_data;
    logic [OFF_W-1:0]  target;
    logic [1:0]        lut_idx, lut_wr_idx;
    logic [PC_W-1:0]   PC;
    logic              halt, ras_overflow, ras_underflow;
    pc_state_t         dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    // Reference model state and the expected queue {run, halt, ovf, unf, pc}.
    int   m_pc;
    bit   m_run, m_halt, m_ovf, m_unf;
    int   m_stack[$];
    int   m_lut[LUT_DEPTH];
    logic [EXP_W-1:0] exp_q[$];

    pc_sequencer #(
        .PC_W(PC_W), .OFF_W(OFF_W), .LUT_DEPTH(LUT_DEPTH),
        .RAS_DEPTH(RAS_DEPTH), .HALT_ADDR(HALT_ADDR)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .start(start), .start_address(start_address),
        .stall(stall), .branch(branch), .taken(taken), .target(target),
        .lut_sel(lut_sel), .lut_idx(lut_idx), .call(call), .ret(ret),
        .lut_wr_en(lut_wr_en), .lut_wr_idx(lut_wr_idx), .lut_wr_data(lut_wr_data),
        .PC(PC), .halt(halt), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow),
        .dbg_state(dbg_state)
    );

    // Clock and reset.
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the sequencing rules in plain integer arithmetic.
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_pc = 0; m_run = 0; m_halt = 0; m_ovf = 0; m_unf = 0;
            m_stack.delete();
            foreach (m_lut[i]) m_lut[i] = 0;
            exp_q.delete();
        end else begin
            int  nxt, dest, off;
            bit  moved;
            off   = $signed(target);
            dest  = lut_sel ? m_lut[lut_idx] : (m_pc + off + MOD) % MOD;
            nxt   = m_pc;
            moved = 0;
            if (start) begin
                nxt = start_address; moved = 1;
                m_stack.delete(); m_ovf = 0; m_unf = 0;
            end else if (m_run && !stall) begin
                moved = 1;
                if (ret) begin
                    if (m_stack.size() > 0) nxt = m_stack.pop_back();
                    else begin nxt = (m_pc + 1) % MOD; m_unf = 1; end
                end else if (call) begin
                    if (m_stack.size() < RAS_DEPTH) m_stack.push_back((m_pc + 1) % MOD);
                    else m_ovf = 1;
                    nxt = dest;
                end else if (branch && taken) begin
                    nxt = dest;
                end else begin
                    nxt = (m_pc + 1) % MOD;
                end
            end
            if (moved) begin
                m_halt = (nxt == HALT_ADDR);
                m_run  = !m_halt;
            end
            m_pc = nxt;
            if (lut_wr_en) m_lut[lut_wr_idx] = lut_wr_data;
            if (check_en) exp_q.push_back({m_run, m_halt, m_ovf, m_unf, PC_W'(m_pc)});
        end
    end

    // Scoreboard compare on the falling edge.
    always @(negedge CLK) begin
        if (RESET_N && exp_q.size() > 0) begin
            logic [EXP_W-1:0] e;
            pc_state_t        e_st;
            e    = exp_q.pop_front();
            e_st = e[EXP_W-2] ? HALT : (e[EXP_W-1] ? RUN : IDLE);
            check("sb_pc", 32'(PC), 32'(e[PC_W-1:0]));
            check("sb_halt", 32'(halt), 32'(e[EXP_W-2]));
            check("sb_ovf", 32'(ras_overflow), 32'(e[EXP_W-3]));
            check("sb_unf", 32'(ras_underflow), 32'(e[EXP_W-4]));
            check("sb_state", 32'(dbg_state), 32'(e_st));
        end
    end

    // Driver tasks.
    task automatic clear_inputs();
        start = 0; start_address = '0; stall = 0; branch = 0; taken = 0;
        target = '0; lut_sel = 0; lut_idx = '0; call = 0; ret = 0;
        lut_wr_en = 0; lut_wr_idx = '0; lut_wr_data = '0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic go(input int addr);
        clear_inputs();
        start = 1; start_address = PC_W'(addr);
        tick();
        clear_inputs();
    endtask

    task automatic step_pc(input string name, input int exp_pc);
        tick();
        check(name, 32'(PC), 32'(exp_pc));
    endtask

    initial begin
        RESET_N = 0;
        clear_inputs();
        repeat (2) @(posedge CLK);
        #2 RESET_N = 1;
        check_en = 1;
        check("rst_pc", 32'(PC), 0);
        check("rst_halt", 32'(halt), 0);
        check("rst_ovf", 32'(ras_overflow), 0);
        check("rst_unf", 32'(ras_underflow), 0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));

        branch = 1; taken = 1; target = 8'd5;
        step_pc("idle_hold", 0);
        clear_inputs();

        // Start and sequential fetch.
        go(5);
        check("start_pc", 32'(PC), 5);
        check("start_halt", 32'(halt), 0);
        step_pc("seq_6", 6);
        step_pc("seq_7", 7);
        step_pc("seq_8", 8);

        // Relative branches.
        go(20);
        branch = 1; taken = 1; target = 8'hFC;
        step_pc("br_neg", 16);
        go(20);
        branch = 1; taken = 0; target = 8'hFC;
        step_pc("br_not_taken", 21);

        // LUT branch with a same-cycle rewrite of the entry being read.
        clear_inputs();
        lut_wr_en = 1; lut_wr_idx = 2; lut_wr_data = 10'd261;
        tick();
        go(30);
        branch = 1; taken = 1; lut_sel = 1; lut_idx = 2;
        lut_wr_en = 1; lut_wr_idx = 2; lut_wr_data = 10'd77;
        step_pc("lut_old", 261);
        clear_inputs();
        branch = 1; taken = 1; lut_sel = 1; lut_idx = 2;
        step_pc("lut_new", 77);

        // Call / return.
        go(10);
        call = 1; target = 8'd40;
        step_pc("call_rel", 50);
        clear_inputs(); ret = 1;
        step_pc("ret_pop", 11);

        go(100);
        call = 1; target = 8'd1;
        repeat (RAS_DEPTH + 1) tick();
        check("nest_pc", 32'(PC), 105);
        check("nest_ovf", 32'(ras_overflow), 1);
        check("nest_unf", 32'(ras_underflow), 0);
        clear_inputs(); ret = 1;
        for (int i = 0; i < RAS_DEPTH; i++) step_pc("nest_ret", 104 - i);
        step_pc("ret_empty", 102);
        check("unf_set", 32'(ras_underflow), 1);
        check("ovf_sticky", 32'(ras_overflow), 1);
        go(200);
        check("start_clr_ovf", 32'(ras_overflow), 0);
        check("start_clr_unf", 32'(ras_underflow), 0);

        go(300);
        call = 1; target = 8'd10;
        step_pc("call_300", 310);
        call = 1; ret = 1; target = 8'd3;
        step_pc("ret_wins", 301);

        go(400);
        call = 1; lut_sel = 1; lut_idx = 2;
        step_pc("call_lut", 77);
        clear_inputs(); ret = 1;
        step_pc("ret_lut", 401);

        // Halt, writes while halted, restart and wrap-around.
        go(1022);
        step_pc("reach_halt", 1023);
        check("halt_set", 32'(halt), 1);
        check("halt_state", 32'(dbg_state), 32'(HALT));
        branch = 1; taken = 1; target = 8'd5; call = 1;
        lut_wr_en = 1; lut_wr_idx = 1; lut_wr_data = 10'd500;
        step_pc("halt_hold", 1023);
        check("halt_still", 32'(halt), 1);
        go(7);
        check("restart_pc", 32'(PC), 7);
        check("restart_halt", 32'(halt), 0);
        branch = 1; taken = 1; lut_sel = 1; lut_idx = 1;
        step_pc("halt_lut_wr", 500);
        go(1020);
        branch = 1; taken = 1; target = 8'd10;
        step_pc("wrap_up", 6);
        go(2);
        branch = 1; taken = 1; target = 8'hF0;
        step_pc("wrap_down", 1010);
        go(1000);
        branch = 1; taken = 1; target = 8'd23;
        step_pc("br_to_halt", 1023);
        check("br_halt", 32'(halt), 1);
        go(1023);
        check("start_halt_addr", 32'(halt), 1);

        // Stall and asynchronous mid-cycle reset.
        go(50);
        stall = 1; call = 1; target = 8'd5;
        for (int i = 0; i < 3; i++) step_pc("stall_hold", 50);
        clear_inputs();
        step_pc("stall_release", 51);
        call = 1; target = 8'd2;
        step_pc("pre_rst_call", 53);
        clear_inputs();
        #1 RESET_N = 0;
        #1;
        check("async_rst_pc", 32'(PC), 0);
        check("async_rst_state", 32'(dbg_state), 32'(IDLE));
        check("async_rst_halt", 32'(halt), 0);
        RESET_N = 1;
        go(60);
        ret = 1;
        step_pc("ras_cleared", 61);
        check("ras_cleared_unf", 32'(ras_underflow), 1);

        clear_inputs();
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
